// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use / multiply stall unit for the 5-stage pipeline
// Optional multicycle-multiply tracking is enabled by defining FWD_MUL_EN.
module fwd_hazard_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NSRC    = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_rs,
    input  logic [NSRC-1:0]          id_rs_used,
    input  logic [NSRC*DATA_W-1:0]   id_q,
    input  logic                     id_wreg,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_m2reg,
    input  logic                     id_mul,
    input  logic [DATA_W-1:0]        exe_r,
    input  logic [DATA_W-1:0]        mem_r,
    input  logic [DATA_W-1:0]        mem_mdo,
    output logic [2*NSRC-1:0]        fwd_sel,
    output logic [NSRC*DATA_W-1:0]   fwd_q,
    output logic                     stall,
    output logic                     exe_hold,
    output logic                     mul_busy
);

    logic              exe_v_q, exe_v_d;
    logic              exe_wreg_q, exe_wreg_d;
    logic [REG_AW-1:0] exe_rd_q, exe_rd_d;
    logic              exe_m2reg_q, exe_m2reg_d;
    logic              mem_v_q, mem_v_d;
    logic              mem_wreg_q, mem_wreg_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_m2reg_q, mem_m2reg_d;

`ifdef FWD_MUL_EN
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic              exe_mul_q, exe_mul_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
    logic              unused_mul;
    assign unused_mul = id_mul & (MUL_LAT > 1);
`endif

    logic              busy;
    logic              exe_mul_pend;
    logic              load_use;
    logic [NSRC-1:0]   exe_hit;
    logic [NSRC-1:0]   mem_hit;

    // A multiply still counting down in EXE has no usable result on exe_r yet.
    always_comb begin
`ifdef FWD_MUL_EN
        exe_mul_pend = exe_mul_q && (cnt_q != '0);
        busy         = exe_v_q && exe_mul_pend;
`else
        exe_mul_pend = 1'b0;
        busy         = 1'b0;
`endif
    end

    genvar g;
    for (g = 0; g < NSRC; g++) begin : g_src
        logic [REG_AW-1:0] rs;
        logic [1:0]        sel;

        assign rs         = id_rs[g*REG_AW +: REG_AW];
        assign exe_hit[g] = id_rs_used[g] && (rs != '0) && exe_v_q && exe_wreg_q && (exe_rd_q == rs);
        assign mem_hit[g] = id_rs_used[g] && (rs != '0) && mem_v_q && mem_wreg_q && (mem_rd_q == rs);

        always_comb begin
            sel = 2'b00;
            if (exe_hit[g] && !exe_m2reg_q && !exe_mul_pend) begin
                sel = 2'b01;
            end else if (mem_hit[g] && mem_m2reg_q) begin
                sel = 2'b11;
            end else if (mem_hit[g]) begin
                sel = 2'b10;
            end
        end

        assign fwd_sel[2*g +: 2]        = sel;
        assign fwd_q[g*DATA_W +: DATA_W] = (sel == 2'b01) ? exe_r   :
                                           (sel == 2'b11) ? mem_mdo :
                                           (sel == 2'b10) ? mem_r   :
                                                            id_q[g*DATA_W +: DATA_W];
    end

    assign load_use = (|exe_hit) && exe_m2reg_q;
    assign stall    = (id_valid && load_use) || busy;
    assign exe_hold = busy;
    assign mul_busy = busy;

    always_comb begin
        exe_v_d     = exe_v_q;
        exe_wreg_d  = exe_wreg_q;
        exe_rd_d    = exe_rd_q;
        exe_m2reg_d = exe_m2reg_q;
        mem_v_d     = mem_v_q;
        mem_wreg_d  = mem_wreg_q;
        mem_rd_d    = mem_rd_q;
        mem_m2reg_d = mem_m2reg_q;
`ifdef FWD_MUL_EN
        exe_mul_d   = exe_mul_q;
        cnt_d       = cnt_q;
`endif
        if (busy) begin
            mem_v_d = 1'b0;
`ifdef FWD_MUL_EN
            cnt_d   = cnt_q - CNT_W'(1);
`endif
        end else if (load_use) begin
            mem_v_d     = exe_v_q;
            mem_wreg_d  = exe_wreg_q;
            mem_rd_d    = exe_rd_q;
            mem_m2reg_d = exe_m2reg_q;
            exe_v_d     = 1'b0;
`ifdef FWD_MUL_EN
            cnt_d       = '0;
`endif
        end else begin
            mem_v_d     = exe_v_q;
            mem_wreg_d  = exe_wreg_q;
            mem_rd_d    = exe_rd_q;
            mem_m2reg_d = exe_m2reg_q;
            exe_v_d     = id_valid;
            exe_wreg_d  = id_wreg;
            exe_rd_d    = id_rd;
            exe_m2reg_d = id_m2reg;
`ifdef FWD_MUL_EN
            exe_mul_d   = id_mul;
            cnt_d       = (id_valid && id_mul) ? CNT_W'(MUL_LAT - 1) : '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_v_q     <= 1'b0;
            exe_wreg_q  <= 1'b0;
            exe_rd_q    <= '0;
            exe_m2reg_q <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_wreg_q  <= 1'b0;
            mem_rd_q    <= '0;
            mem_m2reg_q <= 1'b0;
`ifdef FWD_MUL_EN
            exe_mul_q   <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            exe_v_q     <= exe_v_d;
            exe_wreg_q  <= exe_wreg_d;
            exe_rd_q    <= exe_rd_d;
            exe_m2reg_q <= exe_m2reg_d;
            mem_v_q     <= mem_v_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_rd_q    <= mem_rd_d;
            mem_m2reg_q <= mem_m2reg_d;
`ifdef FWD_MUL_EN
            exe_mul_q   <= exe_mul_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed vectors plus randomized checks against a pipeline model
module tb_fwd_hazard_unit;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NSRC    = 2;
    localparam int MUL_LAT = 4;
`ifdef FWD_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   id_valid;
    logic [NSRC*REG_AW-1:0] id_rs;
    logic [NSRC-1:0]        id_rs_used;
    logic [NSRC*DATA_W-1:0] id_q;
    logic                   id_wreg;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_m2reg;
    logic                   id_mul;
    logic [DATA_W-1:0]      exe_r;
    logic [DATA_W-1:0]      mem_r;
    logic [DATA_W-1:0]      mem_mdo;
    logic [2*NSRC-1:0]      fwd_sel;
    logic [NSRC*DATA_W-1:0] fwd_q;
    logic                   stall;
    logic                   exe_hold;
    logic                   mul_busy;

    fwd_hazard_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_q(id_q), .id_wreg(id_wreg), .id_rd(id_rd), .id_m2reg(id_m2reg), .id_mul(id_mul),
        .exe_r(exe_r), .mem_r(mem_r), .mem_mdo(mem_mdo), .fwd_sel(fwd_sel), .fwd_q(fwd_q),
        .stall(stall), .exe_hold(exe_hold), .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        int          rs0, rs1;
        logic [1:0]  used;
        logic [31:0] q0, q1;
        logic        wreg;
        int          rd;
        logic        m2reg, mul;
        logic [31:0] exr, mmr, mdo;
        logic [3:0]  esel;
        logic [31:0] eq0, eq1;
        logic        estall, ebusy;
    } vec_t;

    typedef struct {
        bit v, wreg, m2reg, mul;
        int rd;
    } ins_t;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];
    ins_t m_ex, m_me;
    int   m_left;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input int rs0, input int rs1, input logic [1:0] used,
                                input logic [31:0] q0, input logic [31:0] q1, input logic wreg,
                                input int rd, input logic m2reg, input logic mul,
                                input logic [31:0] exr, input logic [31:0] mmr, input logic [31:0] mdo,
                                input logic [3:0] esel, input logic [31:0] eq0, input logic [31:0] eq1,
                                input logic estall, input logic ebusy);
        vec_t v;
        v.valid = valid; v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.q0 = q0; v.q1 = q1;
        v.wreg = wreg; v.rd = rd; v.m2reg = m2reg; v.mul = mul;
        v.exr = exr; v.mmr = mmr; v.mdo = mdo;
        v.esel = esel; v.eq0 = eq0; v.eq1 = eq1; v.estall = estall; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid   = v.valid;
        id_rs      = {REG_AW'(v.rs1), REG_AW'(v.rs0)};
        id_rs_used = v.used;
        id_q       = {v.q1, v.q0};
        id_wreg    = v.wreg;
        id_rd      = REG_AW'(v.rd);
        id_m2reg   = v.m2reg;
        id_mul     = v.mul;
        exe_r      = v.exr;
        mem_r      = v.mmr;
        mem_mdo    = v.mdo;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit hits(input ins_t s, input int rs, input bit used);
        return used && rs != 0 && s.v && s.wreg && s.rd == rs;
    endfunction

    // Expected selector for one source from the model pipeline contents.
    function automatic logic [1:0] model_sel(input int rs, input bit used);
        bit mul_wait;
        mul_wait = m_ex.mul && m_left > 0;
        if (hits(m_ex, rs, used) && !m_ex.m2reg && !mul_wait) return 2'b01;
        if (hits(m_me, rs, used) && m_me.m2reg) return 2'b11;
        if (hits(m_me, rs, used)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] regq);
        case (s)
            2'b01:   return exe_r;
            2'b10:   return mem_r;
            2'b11:   return mem_mdo;
            default: return regq;
        endcase
    endfunction

    task automatic model_clear();
        m_ex   = '{v: 0, wreg: 0, m2reg: 0, mul: 0, rd: 0};
        m_me   = m_ex;
        m_left = 0;
    endtask

    task automatic model_step_check(input int cyc);
        int         rs0, rs1;
        bit         u0, u1, busy, lu, st;
        logic [1:0] s0, s1;
        ins_t       nid;
        rs0  = int'(id_rs[REG_AW-1:0]);
        rs1  = int'(id_rs[2*REG_AW-1:REG_AW]);
        u0   = id_rs_used[0];
        u1   = id_rs_used[1];
        s0   = model_sel(rs0, u0);
        s1   = model_sel(rs1, u1);
        busy = m_ex.v && m_ex.mul && m_left > 0;
        lu   = (hits(m_ex, rs0, u0) || hits(m_ex, rs1, u1)) && m_ex.m2reg;
        st   = (id_valid && lu) || busy;
        chk($sformatf("rnd%0d fwd_sel", cyc), 64'(fwd_sel), 64'({s1, s0}));
        chk($sformatf("rnd%0d fwd_q", cyc), 64'(fwd_q),
            {pick(s1, id_q[63:32]), pick(s0, id_q[31:0])});
        chk($sformatf("rnd%0d stall", cyc), 64'(stall), 64'(st));
        chk($sformatf("rnd%0d mul_busy", cyc), 64'(mul_busy), 64'(busy));
        chk($sformatf("rnd%0d exe_hold", cyc), 64'(exe_hold), 64'(busy));
        if (busy) begin
            m_left--;
            m_me.v = 0;
        end else if (lu) begin
            m_me   = m_ex;
            m_ex.v = 0;
            m_left = 0;
        end else begin
            nid.v     = id_valid;
            nid.wreg  = id_wreg;
            nid.rd    = int'(id_rd);
            nid.m2reg = id_m2reg;
            nid.mul   = MUL_EN && id_mul;
            m_me      = m_ex;
            m_ex      = nid;
            m_left    = (MUL_EN && id_valid && id_mul) ? MUL_LAT - 1 : 0;
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        v = mk(1, 3, 4, 2'b11, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 'h11, 'h22, 0, 0);
        drive(v);
        #2;
        chk("reset fwd_sel", 64'(fwd_sel), 64'd0);
        chk("reset fwd_q", 64'(fwd_q), {32'h22, 32'h11});
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset mul_busy", 64'(mul_busy), 64'd0);
        chk("reset exe_hold", 64'(exe_hold), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(mk(1, 3, 4, 2'b11, 'h11, 'h22, 1, 5, 0, 0, 0, 0, 0, 4'b0000, 'h11, 'h22, 0, 0));
        vecs.push_back(mk(1, 5, 0, 2'b01, 'h55, 0, 0, 0, 0, 0, 'hA5, 0, 0, 4'b0001, 'hA5, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 2'b01, 'h55, 0, 1, 7, 1, 0, 'h77, 'hA5, 0, 4'b0010, 'hA5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 7, 2'b10, 'h44, 'h33, 0, 0, 0, 0, 0, 0, 'hDEAD, 4'b0000, 'h44, 'h33, 1, 0));
        vecs.push_back(mk(1, 0, 7, 2'b10, 'h44, 'h33, 1, 9, 0, 0, 0, 'h99, 'hDEAD, 4'b1100, 'h44, 'hDEAD, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'b00, 'h1, 'h2, 1, 9, 0, 0, 0, 0, 0, 4'b0000, 'h1, 'h2, 0, 0));
        vecs.push_back(mk(1, 9, 9, 2'b11, 'h3, 'h4, 1, 0, 0, 0, 'h1111, 'h2222, 0, 4'b0101, 'h1111, 'h1111, 0, 0));
        vecs.push_back(mk(1, 0, 9, 2'b11, 'hAB, 'hCD, 1, 2, 0, 1, 'h1234, 'h5678, 0, 4'b1000, 'hAB, 'h5678, 0, 0));
`ifdef FWD_MUL_EN
        for (int k = 0; k < MUL_LAT - 1; k++)
            vecs.push_back(mk(1, 2, 0, 2'b01, 'h2, 0, 0, 0, 0, 0, 'h600D, 0, 0, 4'b0000, 'h2, 0, 1, 1));
`endif
        vecs.push_back(mk(1, 2, 0, 2'b01, 'h2, 0, 0, 0, 0, 0, 'h600D, 0, 0, 4'b0001, 'h600D, 0, 0, 0));

        foreach (vecs[k]) begin
            drive(vecs[k]);
            #1;
            chk($sformatf("vec%0d fwd_sel", k), 64'(fwd_sel), 64'(vecs[k].esel));
            chk($sformatf("vec%0d fwd_q", k), 64'(fwd_q), {vecs[k].eq1, vecs[k].eq0});
            chk($sformatf("vec%0d stall", k), 64'(stall), 64'(vecs[k].estall));
            chk($sformatf("vec%0d mul_busy", k), 64'(mul_busy), 64'(vecs[k].ebusy));
            chk($sformatf("vec%0d exe_hold", k), 64'(exe_hold), 64'(vecs[k].ebusy));
            @(negedge clk);
        end

        // Reset arriving while a multiply is counting down.
        do_reset();
        drive(mk(1, 0, 0, 2'b00, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 2, 0, 2'b01, 'h2, 'h8, 0, 0, 0, 0, 'hBEEF, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("midmul busy before rst", 64'(mul_busy), 64'(MUL_EN));
        rst = 1'b1;
        #1;
        chk("midmul busy after rst", 64'(mul_busy), 64'd0);
        chk("midmul hold after rst", 64'(exe_hold), 64'd0);
        chk("midmul stall after rst", 64'(stall), 64'd0);
        chk("midmul sel after rst", 64'(fwd_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midmul q after release", 64'(fwd_q), {32'h8, 32'h2});

        // Randomized run against the model; occasional asynchronous resets.
        @(negedge clk);
        model_clear();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                model_clear();
            end
            id_valid   = ($urandom_range(0, 99) < 85);
            id_rs      = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
            id_rs_used = 2'($urandom_range(0, 3));
            id_q       = {$urandom, $urandom};
            id_wreg    = ($urandom_range(0, 99) < 70);
            id_rd      = REG_AW'($urandom_range(0, 7));
            id_m2reg   = ($urandom_range(0, 99) < 25);
            id_mul     = ($urandom_range(0, 99) < 15);
            exe_r      = $urandom;
            mem_r      = $urandom;
            mem_mdo    = $urandom;
            #1;
            model_step_check(c);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
